// File: rtl/pdh_out_pkg.sv
// Shared types and constants for the PID-to-DAC output stage.
//   state_e    : lock FSM encoding (IDLE=0, ACQUIRE=1, LOCKED=2)
//   DAC_MID    : offset-binary code that maps to DAC code 0
//   PID_MID    : PID output midscale
//   FULL_SCALE : largest 14-bit unsigned code
//   abs17()    : magnitude of a 16-bit signed value, widened so -32768 is exact
package pdh_out_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  localparam logic [13:0] DAC_MID    = 14'd8192;
  localparam logic [13:0] PID_MID    = 14'd8191;
  localparam logic [13:0] FULL_SCALE = 14'd16383;

  function automatic logic [16:0] abs17(input logic [15:0] v);
    logic [16:0] ext;
    ext = {v[15], v};
    return v[15] ? (17'd0 - ext) : ext;
  endfunction

endpackage

// File: rtl/slew_limiter.sv
// Slew-rate limited output register.
//   clk, rst     : clock, asynchronous active-high reset
//   enable_i     : low parks the output at DAC_MID on the next clock
//   target_i     : already-clamped target code (unsigned, 14 bit)
//   step_i       : maximum change per clock; 0 disables the limit
//   y_o          : registered output code
//   y_next_o     : value y_o takes on the next clock
module slew_limiter
  import pdh_out_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_i,
  input  logic [13:0] target_i,
  input  logic [13:0] step_i,
  output logic [13:0] y_o,
  output logic [13:0] y_next_o
);

  logic [13:0]        y_q, y_d;
  logic signed [14:0] delta;
  logic [14:0]        delta_mag;

  // Both operands are non-negative 14-bit, so 15-bit signed holds the difference exactly.
  assign delta     = $signed({1'b0, target_i}) - $signed({1'b0, y_q});
  assign delta_mag = delta[14] ? 15'(-delta) : 15'(delta);

  always_comb begin
    y_d = DAC_MID;
    if (enable_i) begin
      if ((step_i != 14'd0) && (delta_mag > {1'b0, step_i})) begin
        y_d = delta[14] ? (y_q - step_i) : (y_q + step_i);
      end else begin
        y_d = target_i;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) y_q <= DAC_MID;
    else     y_q <= y_d;
  end

  assign y_o      = y_q;
  assign y_next_o = y_d;

endmodule

// File: rtl/pid_dac_stage.sv
// PID output to DAC stage: clamp window, slew limit, rail flag and lock detector.
//   clk, rst        : clock, asynchronous active-high reset
//   enable_i        : stage enable
//   pid_i           : PID output, offset binary
//   err_i           : signed error tap used for lock detection
//   step_max_i      : slew limit per clock (0 = no limit)
//   lo_lim_i/hi_lim_i : clamp window; ignored (full scale) when lo > hi
//   lock_thresh_i   : lock window on |err_i|
//   lock_count_i    : consecutive in-window samples to declare lock (0 acts as 1)
//   dac_o           : two's complement DAC code
//   rail_o          : output sits on an effective clamp limit
//   locked_o        : high in LOCKED
//   state_o         : FSM state
//
// state   | meaning
// IDLE    | stage disabled, output parked at midscale, counters cleared
// ACQUIRE | counting consecutive in-window error samples
// LOCKED  | lock declared, counting consecutive misses
module pid_dac_stage
  import pdh_out_pkg::*;
#(
  parameter int MISS_LIMIT = 8,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_i,
  input  logic [13:0]      pid_i,
  input  logic [15:0]      err_i,
  input  logic [13:0]      step_max_i,
  input  logic [13:0]      lo_lim_i,
  input  logic [13:0]      hi_lim_i,
  input  logic [15:0]      lock_thresh_i,
  input  logic [CNT_W-1:0] lock_count_i,
  output logic [13:0]      dac_o,
  output logic             rail_o,
  output logic             locked_o,
  output logic [1:0]       state_o
);

  localparam int MW = $clog2(MISS_LIMIT + 1);

  logic [13:0]      lo_eff, hi_eff, target, y, y_next;
  logic             rail_q, rail_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] in_cnt_q, in_cnt_d, lock_eff;
  logic [CNT_W:0]   in_inc;
  logic [MW-1:0]    miss_cnt_q, miss_cnt_d, miss_inc;
  logic             in_window;

  assign lo_eff = (lo_lim_i <= hi_lim_i) ? lo_lim_i : 14'd0;
  assign hi_eff = (lo_lim_i <= hi_lim_i) ? hi_lim_i : FULL_SCALE;
  assign target = (pid_i < lo_eff) ? lo_eff : ((pid_i > hi_eff) ? hi_eff : pid_i);

  slew_limiter u_slew (
    .clk      (clk),
    .rst      (rst),
    .enable_i (enable_i),
    .target_i (target),
    .step_i   (step_max_i),
    .y_o      (y),
    .y_next_o (y_next)
  );

  assign rail_d = enable_i && ((y_next == lo_eff) || (y_next == hi_eff));

  assign in_window = abs17(err_i) <= {1'b0, lock_thresh_i};
  assign lock_eff  = (lock_count_i == '0) ? CNT_W'(1) : lock_count_i;
  assign in_inc    = {1'b0, in_cnt_q} + 1'b1;
  assign miss_inc  = miss_cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    in_cnt_d   = in_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (!enable_i) begin
      state_d    = IDLE;
      in_cnt_d   = '0;
      miss_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d    = ACQUIRE;
          in_cnt_d   = '0;
          miss_cnt_d = '0;
        end
        ACQUIRE: begin
          if (in_window) begin
            in_cnt_d = (&in_cnt_q) ? in_cnt_q : in_inc[CNT_W-1:0];
            if (in_inc >= {1'b0, lock_eff}) begin
              state_d    = LOCKED;
              miss_cnt_d = '0;
            end
          end else begin
            in_cnt_d = '0;
          end
        end
        LOCKED: begin
          if (!in_window) begin
            if (miss_inc == MW'(MISS_LIMIT)) begin
              state_d    = ACQUIRE;
              in_cnt_d   = '0;
              miss_cnt_d = '0;
            end else begin
              miss_cnt_d = miss_inc;
            end
          end else begin
            miss_cnt_d = '0;
          end
        end
        default: begin
          state_d    = IDLE;
          in_cnt_d   = '0;
          miss_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      in_cnt_q   <= '0;
      miss_cnt_q <= '0;
      rail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_cnt_q   <= in_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      rail_q     <= rail_d;
    end
  end

  // Offset binary to two's complement: subtracting 8192 only flips the MSB.
  assign dac_o    = {~y[13], y[12:0]};
  assign rail_o   = rail_q;
  assign locked_o = (state_q == LOCKED);
  assign state_o  = state_q;

endmodule

// File: tb/tb_pid_dac_stage.sv
module tb_pid_dac_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable_i;
  logic [13:0] pid_i;
  logic [15:0] err_i;
  logic [13:0] step_max_i;
  logic [13:0] lo_lim_i;
  logic [13:0] hi_lim_i;
  logic [15:0] lock_thresh_i;
  logic [15:0] lock_count_i;
  logic [13:0] dac_o;
  logic        rail_o;
  logic        locked_o;
  logic [1:0]  state_o;

  int checks = 0;
  int errors = 0;

  // Expected observation packed as {dac, rail, state, locked}.
  logic [17:0] exp_q[$];
  logic [17:0] got, expv;

  pid_dac_stage #(.MISS_LIMIT(8), .CNT_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .enable_i      (enable_i),
    .pid_i         (pid_i),
    .err_i         (err_i),
    .step_max_i    (step_max_i),
    .lo_lim_i      (lo_lim_i),
    .hi_lim_i      (hi_lim_i),
    .lock_thresh_i (lock_thresh_i),
    .lock_count_i  (lock_count_i),
    .dac_o         (dac_o),
    .rail_o        (rail_o),
    .locked_o      (locked_o),
    .state_o       (state_o)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] mk(input int dac, input bit rail, input int st);
    logic [13:0] d;
    logic [1:0]  s;
    d = 14'(dac);
    s = 2'(st);
    return {d, rail, s, (st == 2)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable_i = 1'b0; pid_i = 14'd8192; err_i = 16'd0;
    step_max_i = 14'd0; lo_lim_i = 14'd0; hi_lim_i = 14'd16383;
    lock_thresh_i = 16'd50; lock_count_i = 16'd10;
    #2;
    got = {dac_o, rail_o, state_o, locked_o}; expv = mk(0, 0, 0);
    checks++;
    if (got !== expv) begin
      errors++; $display("FAIL reset_asserted got=%h exp=%h", got, expv);
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(mk(0, 0, 0));
      tick();
      got = {dac_o, rail_o, state_o, locked_o}; expv = exp_q.pop_front();
      checks++;
      if (got !== expv) begin
        errors++; $display("FAIL idle_after_reset cyc%0d got=%h exp=%h", i, got, expv);
      end
    end
  endtask

  task automatic test_slew_ramp();
    step_max_i = 14'd100; pid_i = 14'd8692; err_i = 16'd1000; enable_i = 1'b1;
    for (int k = 1; k <= 7; k++) exp_q.push_back(mk((k < 5 ? k : 5) * 100, 0, 1));
    exp_q.push_back(mk(0, 0, 0));
    for (int k = 1; k <= 8; k++) begin
      if (k == 8) enable_i = 1'b0;
      tick();
      got = {dac_o, rail_o, state_o, locked_o}; expv = exp_q.pop_front();
      checks++;
      if (got !== expv) begin
        errors++; $display("FAIL slew_ramp cyc%0d got=%h exp=%h", k, got, expv);
      end
    end
  endtask

  task automatic test_clamp_rail();
    int pids[10]  = '{12000, 12000, 5000, 16383, 0, 150, 150, 0, 0, 0};
    int los[10]   = '{4000, 4000, 4000, 9000, 9000, 0, 0, 0, 0, 0};
    int his[10]   = '{9000, 9000, 9000, 4000, 4000, 16383, 16383, 16383, 16383, 16383};
    int steps[10] = '{0, 0, 0, 0, 0, 100, 100, 100, 100, 100};
    int dacs[10]  = '{808, 808, 13192, 8191, 8192, 8292, 8342, 8242, 8192, 0};
    bit rails[10] = '{1, 1, 0, 1, 1, 0, 0, 0, 1, 0};
    int sts[10]   = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    err_i = 16'd1000;
    for (int i = 0; i < 10; i++) begin
      enable_i = (i != 9); pid_i = 14'(pids[i]); lo_lim_i = 14'(los[i]);
      hi_lim_i = 14'(his[i]); step_max_i = 14'(steps[i]);
      exp_q.push_back(mk(dacs[i], rails[i], sts[i]));
      tick();
      got = {dac_o, rail_o, state_o, locked_o}; expv = exp_q.pop_front();
      checks++;
      if (got !== expv) begin
        errors++; $display("FAIL clamp_rail step%0d got=%h exp=%h", i, got, expv);
      end
    end
  endtask

  task automatic test_lock_acq();
    step_max_i = 14'd0; pid_i = 14'd8192; lo_lim_i = 14'd0; hi_lim_i = 14'd16383;
    lock_thresh_i = 16'd50; lock_count_i = 16'd10; enable_i = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      err_i = (i == 0) ? 16'd1000 : 16'd20;
      exp_q.push_back(mk(0, 0, (i == 10) ? 2 : 1));
      tick();
      got = {dac_o, rail_o, state_o, locked_o}; expv = exp_q.pop_front();
      checks++;
      if (got !== expv) begin
        errors++; $display("FAIL lock_acq sample%0d got=%h exp=%h", i, got, expv);
      end
    end
  endtask

  task automatic test_lock_loss();
    err_i = 16'h8000;
    for (int i = 1; i <= 8; i++) begin
      exp_q.push_back(mk(0, 0, (i == 8) ? 1 : 2));
      tick();
      got = {dac_o, rail_o, state_o, locked_o}; expv = exp_q.pop_front();
      checks++;
      if (got !== expv) begin
        errors++; $display("FAIL lock_loss miss%0d got=%h exp=%h", i, got, expv);
      end
    end
  endtask

  task automatic test_lock_restart();
    int errs[5] = '{20, 50, -50, 20, 60};
    for (int i = 1; i <= 15; i++) begin
      err_i = (i <= 5) ? 16'(errs[i-1]) : ((i % 2) ? 16'hFFCE : 16'd7);
      exp_q.push_back(mk(0, 0, (i == 15) ? 2 : 1));
      tick();
      got = {dac_o, rail_o, state_o, locked_o}; expv = exp_q.pop_front();
      checks++;
      if (got !== expv) begin
        errors++; $display("FAIL lock_restart sample%0d got=%h exp=%h", i, got, expv);
      end
    end
  endtask

  task automatic test_lock_hold();
    for (int i = 1; i <= 17; i++) begin
      enable_i = (i != 17);
      err_i = (i == 8) ? 16'd0 : 16'h8000;
      exp_q.push_back(mk(0, 0, (i == 17) ? 0 : ((i == 16) ? 1 : 2)));
      tick();
      got = {dac_o, rail_o, state_o, locked_o}; expv = exp_q.pop_front();
      checks++;
      if (got !== expv) begin
        errors++; $display("FAIL lock_hold sample%0d got=%h exp=%h", i, got, expv);
      end
    end
  endtask

  task automatic test_count_zero();
    lock_count_i = 16'd0; err_i = 16'd0; enable_i = 1'b1;
    exp_q.push_back(mk(0, 0, 1));
    exp_q.push_back(mk(0, 0, 2));
    for (int i = 0; i < 2; i++) begin
      tick();
      got = {dac_o, rail_o, state_o, locked_o}; expv = exp_q.pop_front();
      checks++;
      if (got !== expv) begin
        errors++; $display("FAIL count_zero cyc%0d got=%h exp=%h", i, got, expv);
      end
    end
    lock_count_i = 16'd10;
  endtask

  task automatic test_abs_boundary();
    err_i = 16'h8000;
    for (int i = 1; i <= 16; i++) begin
      lock_thresh_i = (i <= 8) ? 16'd32768 : 16'd32767;
      exp_q.push_back(mk(0, 0, (i == 16) ? 1 : 2));
      tick();
      got = {dac_o, rail_o, state_o, locked_o}; expv = exp_q.pop_front();
      checks++;
      if (got !== expv) begin
        errors++; $display("FAIL abs_boundary sample%0d got=%h exp=%h", i, got, expv);
      end
    end
    lock_thresh_i = 16'd50;
  endtask

  task automatic test_async_reset();
    step_max_i = 14'd100; pid_i = 14'd12000; err_i = 16'd1000; enable_i = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      exp_q.push_back(mk(k * 100, 0, 1));
      tick();
      got = {dac_o, rail_o, state_o, locked_o}; expv = exp_q.pop_front();
      checks++;
      if (got !== expv) begin
        errors++; $display("FAIL async_ramp cyc%0d got=%h exp=%h", k, got, expv);
      end
    end
    #2 rst = 1'b1;
    #1;
    got = {dac_o, rail_o, state_o, locked_o}; expv = mk(0, 0, 0);
    checks++;
    if (got !== expv) begin
      errors++; $display("FAIL async_abort got=%h exp=%h", got, expv);
    end
    tick();
    rst = 1'b0;
    exp_q.push_back(mk(100, 0, 1));
    tick();
    got = {dac_o, rail_o, state_o, locked_o}; expv = exp_q.pop_front();
    checks++;
    if (got !== expv) begin
      errors++; $display("FAIL post_reset_acquire got=%h exp=%h", got, expv);
    end
  endtask

  initial begin
    test_reset();
    test_slew_ramp();
    test_clamp_rail();
    test_lock_acq();
    test_lock_loss();
    test_lock_restart();
    test_lock_hold();
    test_count_zero();
    test_abs_boundary();
    test_async_reset();
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain left=%0d required=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pid_dac_stage.md
PID_DAC_STAGE -- requirements
Module: pid_dac_stage

Interface
REQ-001 Parameter MISS_LIMIT, default 8: consecutive out-of-window samples that drop LOCKED back to ACQUIRE.
REQ-002 Parameter CNT_W, default 16: width of the lock counter and of lock_count_i.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 enable_i  input  1  stage enable; same timing as the PID stage enable.
REQ-006 pid_i  input  14  PID output, unsigned offset-binary, midscale 8191.
REQ-007 err_i  input  16  signed error tap from the PID stage.
REQ-008 step_max_i  input  14  maximum output change per clock, unsigned; 0 = slew limit bypassed.
REQ-009 lo_lim_i / hi_lim_i  input  14 each  unsigned clamp window on pid_i.
REQ-010 lock_thresh_i  input  16  unsigned lock window on |err_i|.
REQ-011 lock_count_i  input  CNT_W  consecutive in-window samples required to declare lock.
REQ-012 dac_o  output  14  DAC code, two's complement.
REQ-013 rail_o  output  1  output sits on an effective clamp limit.
REQ-014 locked_o  output  1  high in LOCKED.
REQ-015 state_o  output  2  FSM state: IDLE=0, ACQUIRE=1, LOCKED=2.

Function
REQ-016 Effective limits: lo_lim_i/hi_lim_i when lo_lim_i <= hi_lim_i; otherwise 0/16383.
REQ-017 Target = pid_i clamped to the effective limits, computed combinationally.
REQ-018 Slew: with enable_i high, each clock delta = target - y_r, evaluated in 15-bit signed.
REQ-019 If step_max_i != 0 and |delta| > step_max_i, then y_r <= y_r + sign(delta)*step_max_i; otherwise y_r <= target.
REQ-020 Latency: y_r reaches an unlimited target 1 clock after pid_i is applied.
REQ-021 dac_o = y_r - 8192 in 14-bit two's complement, i.e. y_r with bit 13 inverted; combinational from y_r.
REQ-022 rail_o is registered and set when next y_r equals an effective limit; it asserts together with that y_r.
REQ-023 |err_i| is formed in 17 bits, so -32768 gives 32768; in-window means |err_i| <= lock_thresh_i.
REQ-024 lock_count_i = 0 is treated as 1.
REQ-025 IDLE: entered whenever enable_i is low, from any state, on the next clock.
REQ-026 IDLE actions: y_r <= 8192, in_cnt and miss_cnt <= 0, rail_o <= 0.
REQ-027 IDLE -> ACQUIRE on the first clock with enable_i high; in_cnt <= 0 on that clock.
REQ-028 ACQUIRE counting: in-window sample -> in_cnt+1, saturating at the all-ones value; out-of-window sample -> in_cnt <= 0.
REQ-029 ACQUIRE -> LOCKED on the clock where an in-window sample makes in_cnt+1 >= effective lock count; miss_cnt <= 0.
REQ-030 LOCKED counting: out-of-window sample -> miss_cnt+1; in-window sample -> miss_cnt <= 0.
REQ-031 LOCKED -> ACQUIRE when miss_cnt+1 = MISS_LIMIT; in_cnt <= 0, miss_cnt <= 0.
REQ-032 Slew and clamp operate identically in ACQUIRE and LOCKED; lock state never gates dac_o.
REQ-033 Configuration inputs are used directly each clock; a mid-run change takes effect on the next clock.

Reset
REQ-034 On rst: y_r = 8192 (dac_o = 0), rail_o = 0, locked_o = 0, state_o = IDLE, all counters = 0.
REQ-035 rst asserted mid-ramp or mid-lock aborts immediately, asynchronously.
REQ-036 First clock after rst release with enable_i high enters ACQUIRE.

Structure
REQ-037 Package pdh_out_pkg holds: state enum (IDLE, ACQUIRE, LOCKED), DAC_MID = 8192, PID_MID = 8191, FULL_SCALE = 16383.
REQ-038 The clamp + slew datapath is sub-module slew_limiter (inputs target, step, enable; output y); the lock FSM stays in pid_dac_stage.

Verification
REQ-039 Reset and idle: rst, then enable_i = 0 -> dac_o = 0, state_o = 0, locked_o = 0.
REQ-040 Slew ramp: step_max_i = 100, y_r = 8192, pid_i = 8692 -> dac_o = 100, 200, 300, 400, 500, then holds at 500.
REQ-041 Clamp and rail: lo_lim_i = 4000, hi_lim_i = 9000, step_max_i = 0, pid_i = 12000 -> dac_o = 808, rail_o = 1 one clock later.
REQ-042 Invalid limits: lo_lim_i = 9000, hi_lim_i = 4000, pid_i = 16383 -> dac_o = 8191, rail_o = 1.
REQ-043 Lock acquisition: lock_thresh_i = 50, lock_count_i = 10, err_i = 20 for 10 clocks -> locked_o = 1 on the 10th.
REQ-043 (cont.) Same setup, err_i = 60 at sample 5 -> counting restarts from 0.
REQ-044 Lock loss: LOCKED, err_i = -32768 for 8 clocks -> state_o = 1 after the 8th.
REQ-044 (cont.) Same setup, 7 misses then 1 in-window sample -> stays LOCKED; enable_i drop -> IDLE next clock, dac_o = 0.
